ysyx_22050133_axi_arbiter: RTL and testbench
============================================

# ysyx_22050133_axi_arbiter

Two-port request arbiter sitting directly upstream of `ysyx_22050133_axi_master`. Accepts independent transaction requests from the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It grants one requester at a time with round-robin priority and drives the master's single `rw_*` request/data interface. The grant is held until the whole burst, including write response, has completed.

## Interface
- `RW_ADDR_WIDTH`, 32, request address width
- `RW_DATA_WIDTH`, 64, data width
- `clk`  in  1  single clock
- `rst`  in  1  reset, synchronous, active-high
- `ifu_addr_valid_i` / `ifu_addr_ready_o`  in/out  1  IFU request handshake
- `ifu_addr_i`  in  RW_ADDR_WIDTH  IFU address
- `ifu_len_i` / `ifu_size_i` / `ifu_burst_i`  in  8/3/2  IFU burst descriptor
- `ifu_r_valid_o` / `ifu_r_ready_i`  out/in  1  IFU read-data handshake
- `ifu_r_data_o`  out  RW_DATA_WIDTH  IFU read data
- `lsu_addr_valid_i` / `lsu_addr_ready_o`  in/out  1  LSU request handshake
- `lsu_addr_i`, `lsu_we_i`, `lsu_len_i`, `lsu_size_i`, `lsu_burst_i`  in  RW_ADDR_WIDTH/1/8/3/2  LSU request descriptor
- `lsu_w_valid_i` / `lsu_w_ready_o`  in/out  1  LSU write-data handshake
- `lsu_w_data_i`  in  RW_DATA_WIDTH  LSU write data
- `lsu_r_valid_o` / `lsu_r_ready_i`, `lsu_r_data_o`  out/in, out  1, RW_DATA_WIDTH  LSU read data
- `m_addr_valid_o` / `m_addr_ready_i`  out/in  1  request to master
- `m_addr_o`, `m_we_o`, `m_len_o`, `m_size_o`, `m_burst_o`, `m_if_o`  out  RW_ADDR_WIDTH/1/8/3/2/1  request descriptor; `m_if_o`=1 for IFU
- `m_w_valid_o` / `m_w_ready_i`, `m_w_data_o`  out/in, out  1, RW_DATA_WIDTH  write data to master
- `m_r_valid_i` / `m_r_ready_o`, `m_r_data_i`  in/out, in  1, RW_DATA_WIDTH  read data from master

## Operation
- Registers: `state`, `gnt` (0=IFU, 1=LSU), `last` (last granted), `beat_cnt` (8 bit).
- States: IDLE, ADDR, RDATA, WDATA, WRESP.
- IDLE: if exactly one requester is valid, grant it; if both, grant `!last`. Load `gnt`, `last<=gnt`, `beat_cnt<=len`; go to ADDR.
- ADDR: `m_addr_valid_o`=1, descriptor muxed from `gnt`; the granted `*_addr_ready_o`=`m_addr_ready_i`. On handshake: read → RDATA; write → WDATA (or WRESP if the last W beat was accepted in the same cycle).
- RDATA: `m_r_ready_o`=granted `*_r_ready_i`; granted `*_r_valid_o`=`m_r_valid_i`; the other requester's valid is 0. On each beat: if `beat_cnt==0` → IDLE, else decrement.
- W beats are forwarded in ADDR and WDATA for LSU writes: `m_w_valid_o`=`lsu_w_valid_i`, `lsu_w_ready_o`=`m_w_ready_i`. On each beat: if `beat_cnt==0` → WRESP, else decrement.
- WRESP: wait for `m_addr_ready_i`==1. Downstream holds ready low from the cycle after address acceptance until the B response completes. Then → IDLE.
- Ungranted ready/valid outputs are 0. Data buses are passed through unconditionally (`*_r_data_o`=`m_r_data_i`, `m_w_data_o`=`lsu_w_data_i`).
- Requesters hold valid and descriptor stable until ready. The arbiter does not register descriptors.

## Timing
- Reset: state=IDLE, gnt=0, last=1 (first tie goes to IFU), beat_cnt=0. All valid/ready outputs are 0 during reset and in IDLE.
- Arbitration latency: one cycle from request valid in IDLE to `m_addr_valid_o`.
- Back-to-back: after RDATA/WRESP completes, IDLE lasts one cycle before the next grant.
- A `len` of 0 means a single beat. `beat_cnt` never wraps, because the exit happens at 0.
- A request dropped while in ADDR is illegal and is not handled. A reset mid-burst aborts to IDLE with no response to the requester.
- An LSU read never asserts `m_w_valid_o`.

## Structure
- AXI size/burst encodings (`ysyx_22050133_AXI_SIZE_*`, burst types) and the state encodings go in the shared defines header.
- The block is a single module with no sub-module.

## Test plan
- IFU read, addr 0x80000000, len 0, size 8B; master returns 0x1122334455667788 → `m_if_o`=1, `ifu_r_data_o` matches, back to IDLE one cycle after the beat.
- LSU write, addr 0x80001004, size 4B, data 0xdeadbeef; B response delayed 5 cycles → `lsu_addr_ready_o` is asserted exactly once, and the grant is held through WRESP.
- IFU and LSU both valid from reset → IFU is granted first, LSU next; repeated simultaneous requests alternate between them.
- LSU read burst, len 3, with `lsu_r_ready_i` stalled 2 cycles on beat 1 → exactly 4 beats are delivered in order, and IFU sees no `ifu_r_valid_o`.
- IFU request arrives during an LSU write → IFU waits until WRESP completes and is granted in the following IDLE cycle.
- Reset asserted mid-RDATA → the next cycle shows IDLE, all outputs 0 and last=1.

Source files
------------

// File: rtl/ysyx_22050133_axi_arbiter_pkg.sv
// Shared types and encodings for the IFU/LSU request arbiter.
package ysyx_22050133_axi_arbiter_pkg;

    localparam int unsigned RW_ADDR_WIDTH = 32;
    localparam int unsigned RW_DATA_WIDTH = 64;
    localparam int unsigned LEN_WIDTH     = 8;
    localparam int unsigned SIZE_WIDTH    = 3;
    localparam int unsigned BURST_WIDTH   = 2;

    localparam logic [SIZE_WIDTH-1:0] ysyx_22050133_AXI_SIZE_BYTES_1 = 3'b000;
    localparam logic [SIZE_WIDTH-1:0] ysyx_22050133_AXI_SIZE_BYTES_2 = 3'b001;
    localparam logic [SIZE_WIDTH-1:0] ysyx_22050133_AXI_SIZE_BYTES_4 = 3'b010;
    localparam logic [SIZE_WIDTH-1:0] ysyx_22050133_AXI_SIZE_BYTES_8 = 3'b011;

    localparam logic [BURST_WIDTH-1:0] ysyx_22050133_AXI_BURST_FIXED = 2'b00;
    localparam logic [BURST_WIDTH-1:0] ysyx_22050133_AXI_BURST_INCR  = 2'b01;
    localparam logic [BURST_WIDTH-1:0] ysyx_22050133_AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_RDATA = 3'd2,
        ST_WDATA = 3'd3,
        ST_WRESP = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic [RW_ADDR_WIDTH-1:0] addr;
        logic                     we;
        logic [LEN_WIDTH-1:0]     len;
        logic [SIZE_WIDTH-1:0]    size;
        logic [BURST_WIDTH-1:0]   burst;
    } req_desc_t;

endpackage

// File: rtl/ysyx_22050133_axi_arbiter_if.sv
// Bundle of the IFU, LSU and master-side rw_* signals around the arbiter.
interface ysyx_22050133_axi_arbiter_if;
    import ysyx_22050133_axi_arbiter_pkg::*;

    logic                     ifu_addr_valid_i;
    logic                     ifu_addr_ready_o;
    logic [RW_ADDR_WIDTH-1:0] ifu_addr_i;
    logic [LEN_WIDTH-1:0]     ifu_len_i;
    logic [SIZE_WIDTH-1:0]    ifu_size_i;
    logic [BURST_WIDTH-1:0]   ifu_burst_i;
    logic                     ifu_r_valid_o;
    logic                     ifu_r_ready_i;
    logic [RW_DATA_WIDTH-1:0] ifu_r_data_o;

    logic                     lsu_addr_valid_i;
    logic                     lsu_addr_ready_o;
    logic [RW_ADDR_WIDTH-1:0] lsu_addr_i;
    logic                     lsu_we_i;
    logic [LEN_WIDTH-1:0]     lsu_len_i;
    logic [SIZE_WIDTH-1:0]    lsu_size_i;
    logic [BURST_WIDTH-1:0]   lsu_burst_i;
    logic                     lsu_w_valid_i;
    logic                     lsu_w_ready_o;
    logic [RW_DATA_WIDTH-1:0] lsu_w_data_i;
    logic                     lsu_r_valid_o;
    logic                     lsu_r_ready_i;
    logic [RW_DATA_WIDTH-1:0] lsu_r_data_o;

    logic                     m_addr_valid_o;
    logic                     m_addr_ready_i;
    logic [RW_ADDR_WIDTH-1:0] m_addr_o;
    logic                     m_we_o;
    logic [LEN_WIDTH-1:0]     m_len_o;
    logic [SIZE_WIDTH-1:0]    m_size_o;
    logic [BURST_WIDTH-1:0]   m_burst_o;
    logic                     m_if_o;
    logic                     m_w_valid_o;
    logic                     m_w_ready_i;
    logic [RW_DATA_WIDTH-1:0] m_w_data_o;
    logic                     m_r_valid_i;
    logic                     m_r_ready_o;
    logic [RW_DATA_WIDTH-1:0] m_r_data_i;

    modport slave (
        input  ifu_addr_valid_i, ifu_addr_i, ifu_len_i, ifu_size_i, ifu_burst_i, ifu_r_ready_i,
        output ifu_addr_ready_o, ifu_r_valid_o, ifu_r_data_o,
        input  lsu_addr_valid_i, lsu_addr_i, lsu_we_i, lsu_len_i, lsu_size_i, lsu_burst_i,
        input  lsu_w_valid_i, lsu_w_data_i, lsu_r_ready_i,
        output lsu_addr_ready_o, lsu_w_ready_o, lsu_r_valid_o, lsu_r_data_o,
        output m_addr_valid_o, m_addr_o, m_we_o, m_len_o, m_size_o, m_burst_o, m_if_o,
        output m_w_valid_o, m_w_data_o, m_r_ready_o,
        input  m_addr_ready_i, m_w_ready_i, m_r_valid_i, m_r_data_i
    );

    modport master (
        output ifu_addr_valid_i, ifu_addr_i, ifu_len_i, ifu_size_i, ifu_burst_i, ifu_r_ready_i,
        input  ifu_addr_ready_o, ifu_r_valid_o, ifu_r_data_o,
        output lsu_addr_valid_i, lsu_addr_i, lsu_we_i, lsu_len_i, lsu_size_i, lsu_burst_i,
        output lsu_w_valid_i, lsu_w_data_i, lsu_r_ready_i,
        input  lsu_addr_ready_o, lsu_w_ready_o, lsu_r_valid_o, lsu_r_data_o,
        input  m_addr_valid_o, m_addr_o, m_we_o, m_len_o, m_size_o, m_burst_o, m_if_o,
        input  m_w_valid_o, m_w_data_o, m_r_ready_o,
        output m_addr_ready_i, m_w_ready_i, m_r_valid_i, m_r_data_i
    );

endinterface

// File: rtl/ysyx_22050133_axi_arbiter.sv
// Round-robin IFU/LSU arbiter in front of the AXI master; the grant is held
// from address through the last data beat (and the write response).
module ysyx_22050133_axi_arbiter
    import ysyx_22050133_axi_arbiter_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22050133_axi_arbiter_if.slave     bus
);

    arb_state_e           r_state, w_state_n;
    logic                 r_gnt, w_gnt_n;
    logic                 r_last, w_last_n;
    logic [LEN_WIDTH-1:0] r_beat_cnt, w_beat_cnt_n;
    logic                 r_w_done, w_w_done_n;

    req_desc_t w_ifu_desc, w_lsu_desc, w_desc;
    logic      w_is_wr, w_sel, w_w_hs, w_r_hs;

    assign w_ifu_desc = '{addr: bus.ifu_addr_i, we: 1'b0, len: bus.ifu_len_i,
                          size: bus.ifu_size_i, burst: bus.ifu_burst_i};
    assign w_lsu_desc = '{addr: bus.lsu_addr_i, we: bus.lsu_we_i, len: bus.lsu_len_i,
                          size: bus.lsu_size_i, burst: bus.lsu_burst_i};
    assign w_desc     = r_gnt ? w_lsu_desc : w_ifu_desc;
    assign w_is_wr    = r_gnt & bus.lsu_we_i;

    assign bus.m_addr_o     = w_desc.addr;
    assign bus.m_we_o       = w_desc.we;
    assign bus.m_len_o      = w_desc.len;
    assign bus.m_size_o     = w_desc.size;
    assign bus.m_burst_o    = w_desc.burst;
    assign bus.m_if_o       = ~r_gnt;
    assign bus.ifu_r_data_o = bus.m_r_data_i;
    assign bus.lsu_r_data_o = bus.m_r_data_i;
    assign bus.m_w_data_o   = bus.lsu_w_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 1'b0;
            r_last     <= 1'b1;
            r_beat_cnt <= '0;
            r_w_done   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_gnt      <= w_gnt_n;
            r_last     <= w_last_n;
            r_beat_cnt <= w_beat_cnt_n;
            r_w_done   <= w_w_done_n;
        end
    end

    // Next state plus handshake steering; everything is quiet while in reset.
    always_comb begin
        w_state_n            = r_state;
        w_gnt_n              = r_gnt;
        w_last_n             = r_last;
        w_beat_cnt_n         = r_beat_cnt;
        w_w_done_n           = r_w_done;
        w_sel                = 1'b0;
        w_w_hs               = 1'b0;
        w_r_hs               = 1'b0;
        bus.ifu_addr_ready_o = 1'b0;
        bus.lsu_addr_ready_o = 1'b0;
        bus.ifu_r_valid_o    = 1'b0;
        bus.lsu_r_valid_o    = 1'b0;
        bus.lsu_w_ready_o    = 1'b0;
        bus.m_addr_valid_o   = 1'b0;
        bus.m_w_valid_o      = 1'b0;
        bus.m_r_ready_o      = 1'b0;

        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    w_w_done_n = 1'b0;
                    if (bus.ifu_addr_valid_i || bus.lsu_addr_valid_i) begin
                        w_sel        = (bus.ifu_addr_valid_i && bus.lsu_addr_valid_i) ?
                                       ~r_last : bus.lsu_addr_valid_i;
                        w_gnt_n      = w_sel;
                        w_last_n     = w_sel;
                        w_beat_cnt_n = w_sel ? bus.lsu_len_i : bus.ifu_len_i;
                        w_state_n    = ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    bus.m_addr_valid_o = 1'b1;
                    if (r_gnt) bus.lsu_addr_ready_o = bus.m_addr_ready_i;
                    else       bus.ifu_addr_ready_o = bus.m_addr_ready_i;
                    // W may run ahead of the address; r_w_done blocks beats past the last.
                    if (w_is_wr && !r_w_done) begin
                        bus.m_w_valid_o   = bus.lsu_w_valid_i;
                        bus.lsu_w_ready_o = bus.m_w_ready_i;
                        w_w_hs            = bus.lsu_w_valid_i & bus.m_w_ready_i;
                    end
                    if (w_w_hs) begin
                        if (r_beat_cnt == '0) w_w_done_n   = 1'b1;
                        else                  w_beat_cnt_n = r_beat_cnt - LEN_WIDTH'(1);
                    end
                    if (bus.m_addr_ready_i) begin
                        if (!w_is_wr)
                            w_state_n = ST_RDATA;
                        else if (r_w_done || (w_w_hs && r_beat_cnt == '0))
                            w_state_n = ST_WRESP;
                        else
                            w_state_n = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (r_gnt) begin
                        bus.m_r_ready_o   = bus.lsu_r_ready_i;
                        bus.lsu_r_valid_o = bus.m_r_valid_i;
                        w_r_hs            = bus.m_r_valid_i & bus.lsu_r_ready_i;
                    end else begin
                        bus.m_r_ready_o   = bus.ifu_r_ready_i;
                        bus.ifu_r_valid_o = bus.m_r_valid_i;
                        w_r_hs            = bus.m_r_valid_i & bus.ifu_r_ready_i;
                    end
                    if (w_r_hs) begin
                        if (r_beat_cnt == '0) w_state_n    = ST_IDLE;
                        else                  w_beat_cnt_n = r_beat_cnt - LEN_WIDTH'(1);
                    end
                end
                ST_WDATA: begin
                    bus.m_w_valid_o   = bus.lsu_w_valid_i;
                    bus.lsu_w_ready_o = bus.m_w_ready_i;
                    w_w_hs            = bus.lsu_w_valid_i & bus.m_w_ready_i;
                    if (w_w_hs) begin
                        if (r_beat_cnt == '0) w_state_n    = ST_WRESP;
                        else                  w_beat_cnt_n = r_beat_cnt - LEN_WIDTH'(1);
                    end
                end
                ST_WRESP: begin
                    // Master re-raises addr ready only once the B response is done.
                    if (bus.m_addr_ready_i) w_state_n = ST_IDLE;
                end
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050133_axi_arbiter.sv
// Bench for the IFU/LSU arbiter: a table of requests served by a master model,
// with descriptor and read-data scoreboards.
module tb_ysyx_22050133_axi_arbiter;
    import ysyx_22050133_axi_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050133_axi_arbiter_if bus();
    ysyx_22050133_axi_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [63:0] data;
    } req_t;

    typedef struct {
        bit          set_ifu;
        bit          set_lsu;
        bit          we;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [63:0] data;
        int          stall_beat;
        int          resp_dly;
        bit          wresp_ifu;
        bit          exp_if;
    } vec_t;

    req_t        ifu_q[$];
    req_t        lsu_q[$];
    logic [63:0] rd_q[$];
    int          total = 0;
    int          bad   = 0;
    vec_t        vec[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(bit si, bit sl, bit we, logic [7:0] len, logic [2:0] sz,
                                 logic [31:0] a, logic [63:0] d, int sb, int rd, bit wi, bit ei);
        vec_t v;
        v.set_ifu = si; v.set_lsu = sl; v.we = we; v.len = len; v.size = sz;
        v.addr = a; v.data = d; v.stall_beat = sb; v.resp_dly = rd;
        v.wresp_ifu = wi; v.exp_if = ei;
        return v;
    endfunction

    task automatic drive_req(input bit lsu, input req_t rq);
        if (lsu) begin
            lsu_q.push_back(rq);
            bus.lsu_addr_valid_i = 1'b1;
            bus.lsu_addr_i       = rq.addr;
            bus.lsu_we_i         = rq.we;
            bus.lsu_len_i        = rq.len;
            bus.lsu_size_i       = rq.size;
            bus.lsu_burst_i      = ysyx_22050133_AXI_BURST_INCR;
        end else begin
            ifu_q.push_back(rq);
            bus.ifu_addr_valid_i = 1'b1;
            bus.ifu_addr_i       = rq.addr;
            bus.ifu_len_i        = rq.len;
            bus.ifu_size_i       = rq.size;
            bus.ifu_burst_i      = ysyx_22050133_AXI_BURST_INCR;
        end
    endtask

    task automatic idle_check(input string nm);
        chk(nm, 64'({bus.m_addr_valid_o, bus.ifu_addr_ready_o, bus.lsu_addr_ready_o,
                      bus.ifu_r_valid_o, bus.lsu_r_valid_o, bus.m_w_valid_o,
                      bus.lsu_w_ready_o, bus.m_r_ready_o}), 64'(0));
    endtask

    // Acts as the downstream master for one granted transaction; ends at a negedge in IDLE.
    task automatic serve(input bit exp_if, input int stall_beat, input int resp_dly, input bit wresp_ifu);
        req_t rq;
        req_t late;
        int   n;
        int   beat;
        int   stall;
        int   nrdy;
        logic rdy;
        n = 0;
        @(negedge clk);
        while (bus.m_addr_valid_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("arb_latency", 64'(n), 64'(0));
        chk("m_if", 64'(bus.m_if_o), 64'(exp_if));
        if (exp_if) rq = ifu_q.pop_front();
        else        rq = lsu_q.pop_front();
        chk("m_addr", 64'(bus.m_addr_o), 64'(rq.addr));
        chk("m_desc", 64'({bus.m_we_o, bus.m_len_o, bus.m_size_o, bus.m_burst_o}),
            64'({rq.we, rq.len, rq.size, ysyx_22050133_AXI_BURST_INCR}));
        chk("addr_rdy_wait", 64'({bus.ifu_addr_ready_o, bus.lsu_addr_ready_o}), 64'(0));
        nrdy = 0;
        bus.m_addr_ready_i = 1'b1;
        if (rq.we) begin
            bus.lsu_w_valid_i = 1'b1;
            bus.lsu_w_data_i  = rq.data;
            bus.m_w_ready_i   = 1'b1;
        end
        #1;
        chk("addr_rdy", 64'({bus.ifu_addr_ready_o, bus.lsu_addr_ready_o}),
            exp_if ? 64'(2) : 64'(1));
        nrdy += int'(bus.lsu_addr_ready_o);
        chk("w_fwd_addr", 64'({bus.m_w_valid_o, bus.lsu_w_ready_o}), rq.we ? 64'(3) : 64'(0));
        if (rq.we) chk("w_data0", bus.m_w_data_o, rq.data);
        @(posedge clk); #1;
        if (exp_if) bus.ifu_addr_valid_i = 1'b0;
        else        bus.lsu_addr_valid_i = 1'b0;
        bus.m_addr_ready_i = 1'b0;

        if (!rq.we) begin
            beat  = 0;
            stall = (stall_beat >= 0) ? 2 : 0;
            n     = 0;
            if (exp_if) bus.lsu_r_ready_i = 1'b1;
            else        bus.ifu_r_ready_i = 1'b1;
            while (beat <= int'(rq.len) && n < 200) begin
                bus.m_r_valid_i = 1'b1;
                bus.m_r_data_i  = rq.data + 64'(beat);
                rdy = !(beat == stall_beat && stall > 0);
                if (exp_if) bus.ifu_r_ready_i = rdy;
                else        bus.lsu_r_ready_i = rdy;
                if (rdy) rd_q.push_back(rq.data + 64'(beat));
                @(negedge clk);
                chk("r_valid", 64'({bus.ifu_r_valid_o, bus.lsu_r_valid_o}),
                    exp_if ? 64'(2) : 64'(1));
                chk("m_r_ready", 64'(bus.m_r_ready_o), 64'(rdy));
                if (rdy) chk("r_data", exp_if ? bus.ifu_r_data_o : bus.lsu_r_data_o,
                             rd_q.pop_front());
                @(posedge clk); #1;
                if (rdy) beat++;
                else     stall--;
                n++;
            end
            chk("r_beats", 64'(beat), 64'(int'(rq.len) + 1));
            bus.m_r_valid_i   = 1'b0;
            bus.ifu_r_ready_i = 1'b0;
            bus.lsu_r_ready_i = 1'b0;
        end else begin
            beat = 1;
            while (beat <= int'(rq.len)) begin
                bus.lsu_w_data_i = rq.data + 64'(beat);
                @(negedge clk);
                chk("w_fwd", 64'({bus.m_w_valid_o, bus.lsu_w_ready_o}), 64'(3));
                chk("w_data", bus.m_w_data_o, rq.data + 64'(beat));
                nrdy += int'(bus.lsu_addr_ready_o);
                @(posedge clk); #1;
                beat++;
            end
            bus.lsu_w_valid_i = 1'b0;
            for (int i = 0; i < resp_dly; i++) begin
                if (wresp_ifu && i == 1) begin
                    late.addr = 32'h8000_3000; late.we = 1'b0; late.len = 8'd0;
                    late.size = ysyx_22050133_AXI_SIZE_BYTES_8; late.data = 64'h5555_aaaa_0000_0001;
                    drive_req(1'b0, late);
                end
                @(negedge clk);
                chk("wresp_hold", 64'({bus.m_addr_valid_o, bus.lsu_addr_ready_o,
                                       bus.ifu_addr_ready_o, bus.m_w_valid_o, bus.lsu_w_ready_o}),
                    64'(0));
                nrdy += int'(bus.lsu_addr_ready_o);
                @(posedge clk); #1;
            end
            bus.m_addr_ready_i = 1'b1;
            @(posedge clk); #1;
            bus.m_addr_ready_i = 1'b0;
            bus.m_w_ready_i    = 1'b0;
            chk("addr_ready_once", 64'(nrdy), 64'(1));
        end
        @(negedge clk);
        idle_check("idle_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t rq;
        req_t tmp;
        rst = 1'b1;
        bus.ifu_addr_valid_i = 1'b0; bus.ifu_addr_i = '0; bus.ifu_len_i = '0;
        bus.ifu_size_i = '0; bus.ifu_burst_i = '0; bus.ifu_r_ready_i = 1'b0;
        bus.lsu_addr_valid_i = 1'b0; bus.lsu_addr_i = '0; bus.lsu_we_i = 1'b0;
        bus.lsu_len_i = '0; bus.lsu_size_i = '0; bus.lsu_burst_i = '0;
        bus.lsu_w_valid_i = 1'b0; bus.lsu_w_data_i = '0; bus.lsu_r_ready_i = 1'b0;
        bus.m_addr_ready_i = 1'b0; bus.m_w_ready_i = 1'b0;
        bus.m_r_valid_i = 1'b0; bus.m_r_data_i = '0;

        vec[0] = mkv(1, 1, 0, 8'd0, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h8000_0000,
                     64'h1122_3344_5566_7788, -1, 0, 0, 1);
        vec[1] = mkv(0, 0, 0, 8'd0, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h0, 64'h0, -1, 0, 0, 0);
        vec[2] = mkv(1, 1, 0, 8'd1, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h8000_0100,
                     64'ha0a0_0000_0000_0010, -1, 0, 0, 1);
        vec[3] = mkv(1, 0, 0, 8'd0, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h8000_0200,
                     64'hb0b0_0000_0000_0020, -1, 0, 0, 0);
        vec[4] = mkv(0, 0, 0, 8'd0, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h0, 64'h0, -1, 0, 0, 1);
        vec[5] = mkv(0, 1, 1, 8'd0, ysyx_22050133_AXI_SIZE_BYTES_4, 32'h8000_1004,
                     64'h0000_0000_dead_beef, -1, 5, 0, 0);
        vec[6] = mkv(0, 1, 0, 8'd3, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h8000_2000,
                     64'h0101_0202_0303_0400, 1, 0, 0, 0);
        vec[7] = mkv(0, 1, 1, 8'd2, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h8000_2800,
                     64'hc0de_0000_0000_0100, -1, 3, 1, 0);
        vec[8] = mkv(0, 0, 0, 8'd0, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h0, 64'h0, -1, 0, 0, 1);
        vec[9] = mkv(1, 0, 0, 8'd7, ysyx_22050133_AXI_SIZE_BYTES_8, 32'h8000_4000,
                     64'hf000_0000_0000_0000, -1, 0, 0, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_check("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        idle_check("reset_idle");

        for (int i = 0; i < 10; i++) begin
            rq.addr = vec[i].addr; rq.len = vec[i].len;
            rq.size = vec[i].size; rq.data = vec[i].data;
            if (vec[i].set_ifu) begin
                rq.we = 1'b0;
                drive_req(1'b0, rq);
            end
            if (vec[i].set_lsu) begin
                rq.we = vec[i].we;
                drive_req(1'b1, rq);
            end
            serve(vec[i].exp_if, vec[i].stall_beat, vec[i].resp_dly, vec[i].wresp_ifu);
        end

        // Reset in the middle of an IFU read burst.
        rq.addr = 32'h8000_5000; rq.we = 1'b0; rq.len = 8'd3;
        rq.size = ysyx_22050133_AXI_SIZE_BYTES_8; rq.data = 64'h7700_0000_0000_0000;
        drive_req(1'b0, rq);
        @(negedge clk);
        tmp = ifu_q.pop_front();
        chk("rst_seq_addr_valid", 64'(bus.m_addr_valid_o), 64'(1));
        chk("rst_seq_addr", 64'(bus.m_addr_o), 64'(tmp.addr));
        bus.m_addr_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.ifu_addr_valid_i = 1'b0;
        bus.m_addr_ready_i   = 1'b0;
        bus.m_r_valid_i      = 1'b1;
        bus.m_r_data_i       = tmp.data;
        bus.ifu_r_ready_i    = 1'b1;
        @(negedge clk);
        chk("rst_seq_rvalid", 64'(bus.ifu_r_valid_o), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        idle_check("rst_mid_burst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        idle_check("rst_back_idle");
        bus.m_r_valid_i   = 1'b0;
        bus.ifu_r_ready_i = 1'b0;

        rq.addr = 32'h8000_6000; rq.we = 1'b0; rq.len = 8'd0; rq.data = 64'h6666_0000_0000_0001;
        drive_req(1'b0, rq);
        rq.addr = 32'h8000_6800; rq.data = 64'h6666_0000_0000_0002;
        drive_req(1'b1, rq);
        serve(1'b1, -1, 0, 1'b0);
        serve(1'b0, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
